register_file_bypass: RTL and testbench
=======================================

Name: register_file_bypass

Overview:
Parametrised next-generation register file for the processor datapath, sitting between decode and the ALU.
- Two combinational read ports and one synchronous write port.
- Register 0 hardwired to zero (optional).
- Same-cycle write-to-read bypass.
- Hardware clear sequencer that zeroes every entry after reset or on request.
- Datapath is stalled while the sequencer runs, signalled by `busy`.

Parameters:
- WIDTH, 16, data width of each register in bits
- REGISTER_BITS, 4, address width; depth DEPTH = 2^REGISTER_BITS
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register
- BYPASS, 1, 1 = a read of the address being written this cycle returns writeData; 0 = returns the stored value

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clearRequest  input  1  pulse in IDLE starts a full clear sweep
- busy  output  1  high while the clear sweep runs
- shouldWrite  input  1  write strobe, sampled on rising clock edge
- writeAddress  input  REGISTER_BITS  write address
- writeData  input  WIDTH  write data
- register1Address  input  REGISTER_BITS  read port 1 address
- register2Address  input  REGISTER_BITS  read port 2 address
- register1Data  output  WIDTH  read port 1 data (combinational)
- register2Data  output  WIDTH  read port 2 data (combinational)

Behaviour:
- Storage: DEPTH x WIDTH array, no per-entry reset. Contents are initialised only by the clear sweep.
- FSM states: CLEAR, IDLE. Clear counter clearIndex is REGISTER_BITS wide.
- reset asserted (asynchronous):
  - state = CLEAR, clearIndex = 0.
  - busy = 1 immediately; read outputs = 0 immediately.
  - Holds for as long as reset stays high; no array writes occur while reset is high.
- CLEAR, each rising edge with reset low:
  - Array[clearIndex] <= 0, clearIndex <= clearIndex + 1.
  - When clearIndex == DEPTH-1, the edge writes the last entry, goes to IDLE and busy falls. Sweep length is exactly DEPTH edges.
- CLEAR, other inputs:
  - shouldWrite is ignored; those writes are dropped, not queued.
  - clearRequest is ignored.
  - Both read outputs are forced to 0.
- IDLE with clearRequest = 1 at an edge:
  - Next state CLEAR, clearIndex = 0, busy = 1 from that edge.
  - A shouldWrite in that same cycle is dropped.
  - clearRequest wins over shouldWrite.
- IDLE with shouldWrite = 1 and clearRequest = 0:
  - Array[writeAddress] <= writeData at the edge.
  - Exception: when ZERO_REG = 1 and writeAddress = 0, the write is discarded.
- Read, IDLE, each port independent, in priority order:
  1. ZERO_REG = 1 and address = 0: output 0.
  2. BYPASS = 1, shouldWrite = 1, clearRequest = 0 and address == writeAddress: output writeData.
  3. Otherwise: output Array[address].
- Read latency: zero cycles (combinational). Write-to-read latency: zero with BYPASS = 1, one edge with BYPASS = 0.
- Both read ports may address the same entry, or the write address, simultaneously; they return identical data.
- Reset mid-sweep:
  - Sweep restarts from clearIndex = 0 once reset deasserts.
  - busy stays high throughout.
  - Full DEPTH-edge sweep follows.
- Address wrap: clearIndex does not wrap into a second sweep; the FSM leaves CLEAR at DEPTH-1.
- Width rules:
  - writeData is stored unmodified; no sign or zero extension.
  - All-ones data (e.g. 16'hFFFF) is stored and read back exactly.

Test Plan:
- Reset then idle:
  - Assert reset for 3 cycles, release, count edges until busy falls -> busy drops after exactly 16 edges.
  - All 16 registers then read 16'h0000 on both ports.
- Write/read with no bypass (BYPASS = 0):
  - Write 16'hBEEF to r5, then read r5 on port 1 and port 2 in the next cycle -> both ports return 16'hBEEF.
  - In the write cycle itself, port 1 reading r5 returns the old value 16'h0000.
- Bypass (BYPASS = 1):
  - Write 16'h1234 to r7 while port 2 reads r7 in the same cycle -> register2Data = 16'h1234 combinationally before the edge.
- Zero register (ZERO_REG = 1):
  - Write 16'hFFFF to r0, then read r0 on both ports, including while bypassing -> both return 0.
  - With ZERO_REG = 0, the same write reads back 16'hFFFF.
- Clear request with collision:
  - Load r3 = 16'h00AA, then pulse clearRequest together with shouldWrite to r4 = 16'h5555.
  - busy rises and reads return 0 for 16 cycles.
  - Afterwards r3 = 0 and r4 = 0 (write dropped).
  - Writes attempted mid-sweep are also absent afterwards.
- Reset mid-sweep:
  - Assert reset at sweep edge 9 for 1 cycle -> busy stays high.
  - A fresh 16-edge sweep follows from release; busy falls 16 edges after reset deasserts.

Source files
------------

// File: rtl/register_file_bypass_if.sv
// Decode-side bus of the bypassing register file: write port, two read ports,
// and the clear request / busy pair.
interface register_file_bypass_if #(
  parameter int WIDTH         = 16,
  parameter int REGISTER_BITS = 4
);
  logic                     clearRequest;
  logic                     busy;
  logic                     shouldWrite;
  logic [REGISTER_BITS-1:0] writeAddress;
  logic [WIDTH-1:0]         writeData;
  logic [REGISTER_BITS-1:0] register1Address;
  logic [REGISTER_BITS-1:0] register2Address;
  logic [WIDTH-1:0]         register1Data;
  logic [WIDTH-1:0]         register2Data;

  modport master (
    output clearRequest, shouldWrite, writeAddress, writeData,
           register1Address, register2Address,
    input  busy, register1Data, register2Data
  );

  modport slave (
    input  clearRequest, shouldWrite, writeAddress, writeData,
           register1Address, register2Address,
    output busy, register1Data, register2Data
  );
endinterface

// File: rtl/register_file_bypass.sv
// Two-read / one-write register file with optional hardwired zero register,
// same-cycle write bypass and a hardware clear sweep that stalls the datapath.
module register_file_bypass #(
  parameter int WIDTH         = 16,
  parameter int REGISTER_BITS = 4,
  parameter bit ZERO_REG      = 1'b1,
  parameter bit BYPASS        = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  register_file_bypass_if.slave  bus_io
);
  localparam int DEPTH = 1 << REGISTER_BITS;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                   state_q;
  logic [REGISTER_BITS-1:0] clearIndex_q;
  logic                     busy_q;
  logic [WIDTH-1:0]         mem_q [DEPTH];

  logic                     writeLive;
  logic                     wrEn;
  logic [REGISTER_BITS-1:0] wrAddr;
  logic [WIDTH-1:0]         wrData;

  // The sweep visits every entry exactly once and leaves CLEAR on the last one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      clearIndex_q <= '0;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clearIndex_q <= clearIndex_q + 1'b1;
          if (&clearIndex_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus_io.clearRequest) begin
            state_q      <= CLEAR;
            clearIndex_q <= '0;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          state_q      <= CLEAR;
          clearIndex_q <= '0;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  // A clear request in the same cycle as a write takes precedence and drops it.
  assign writeLive = (state_q == IDLE) && bus_io.shouldWrite && !bus_io.clearRequest;

  always_comb begin
    wrEn   = 1'b0;
    wrAddr = bus_io.writeAddress;
    wrData = bus_io.writeData;
    if (state_q == CLEAR) begin
      wrEn   = 1'b1;
      wrAddr = clearIndex_q;
      wrData = '0;
    end else if (writeLive && !(ZERO_REG && (bus_io.writeAddress == '0))) begin
      wrEn = 1'b1;
    end
  end

  // Storage has no per-entry reset; the reset branch only blocks writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
    end else if (wrEn) begin
      mem_q[wrAddr] <= wrData;
    end
  end

  function automatic logic [WIDTH-1:0] readPort(
    input logic [REGISTER_BITS-1:0] addr,
    input logic                     idle,
    input logic                     live,
    input logic [REGISTER_BITS-1:0] wAddr,
    input logic [WIDTH-1:0]         wData,
    input logic [WIDTH-1:0]         stored
  );
    if (!idle)                            return '0;
    if (ZERO_REG && (addr == '0))         return '0;
    if (BYPASS && live && (addr == wAddr)) return wData;
    return stored;
  endfunction

  assign bus_io.register1Data = readPort(bus_io.register1Address, state_q == IDLE, writeLive,
                                         bus_io.writeAddress, bus_io.writeData,
                                         mem_q[bus_io.register1Address]);
  assign bus_io.register2Data = readPort(bus_io.register2Address, state_q == IDLE, writeLive,
                                         bus_io.writeAddress, bus_io.writeData,
                                         mem_q[bus_io.register2Address]);
  assign bus_io.busy = busy_q;
endmodule

// File: tb/tb_register_file_bypass.sv
// Bench for register_file_bypass: one instance with zero register + bypass,
// one plain instance, both driven identically and checked against a model.
module tb_register_file_bypass;
  localparam int W  = 16;
  localparam int RB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cr, sw;
  logic [RB-1:0] wa, a1, a2;
  logic [W-1:0]  wd;

  always #5 clock = ~clock;

  register_file_bypass_if #(.WIDTH(W), .REGISTER_BITS(RB)) busA ();
  register_file_bypass_if #(.WIDTH(W), .REGISTER_BITS(RB)) busB ();

  assign busA.clearRequest     = cr;
  assign busA.shouldWrite      = sw;
  assign busA.writeAddress     = wa;
  assign busA.writeData        = wd;
  assign busA.register1Address = a1;
  assign busA.register2Address = a2;
  assign busB.clearRequest     = cr;
  assign busB.shouldWrite      = sw;
  assign busB.writeAddress     = wa;
  assign busB.writeData        = wd;
  assign busB.register1Address = a1;
  assign busB.register2Address = a2;

  register_file_bypass #(.WIDTH(W), .REGISTER_BITS(RB), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
    .clock(clock), .reset(reset), .bus_io(busA.slave)
  );
  register_file_bypass #(.WIDTH(W), .REGISTER_BITS(RB), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
    .clock(clock), .reset(reset), .bus_io(busB.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: sweepLeft counts remaining clear edges; memories hold contents.
  logic [W-1:0] memA [16];
  logic [W-1:0] memB [16];
  int           sweepLeft = 16;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sweepLeft <= 16;
    end else if (sweepLeft > 0) begin
      memA[4'(16 - sweepLeft)] <= '0;
      memB[4'(16 - sweepLeft)] <= '0;
      sweepLeft <= sweepLeft - 1;
    end else if (cr) begin
      sweepLeft <= 16;
    end else if (sw) begin
      if (wa != 0) memA[wa] <= wd;
      memB[wa] <= wd;
    end
  end

  function automatic logic [W-1:0] expectRead(input bit isA, input logic [RB-1:0] a);
    if (reset || sweepLeft > 0) return '0;
    if (isA && a == 0) return '0;
    if (isA && sw && !cr && a == wa) return wd;
    return isA ? memA[a] : memB[a];
  endfunction

  logic [W-1:0] expBusy;
  always @(negedge clock) begin
    expBusy = {15'b0, (reset || sweepLeft > 0)};
    checkOutput("busyA", {15'b0, busA.busy}, expBusy);
    checkOutput("busyB", {15'b0, busB.busy}, expBusy);
    checkOutput("A.rd1", busA.register1Data, expectRead(1'b1, a1));
    checkOutput("A.rd2", busA.register2Data, expectRead(1'b1, a2));
    checkOutput("B.rd1", busB.register1Data, expectRead(1'b0, a1));
    checkOutput("B.rd2", busB.register2Data, expectRead(1'b0, a2));
  end

  task automatic applyStimulus(input logic c, input logic s, input logic [RB-1:0] wAddr,
                               input logic [W-1:0] wData, input logic [RB-1:0] r1, input logic [RB-1:0] r2);
    cr = c; sw = s; wa = wAddr; wd = wData; a1 = r1; a2 = r2;
  endtask

  task automatic nextEdge();
    @(posedge clock);
    #2;
  endtask

  task automatic countSweep(input string name);
    int n;
    n = 0;
    while (busA.busy && n < 100) begin
      nextEdge();
      n++;
    end
    checkOutput(name, 16'(n), 16'd16);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    countSweep("sweep length after reset");

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 4'(i), 4'(15 - i));
      #1;
      checkOutput("cleared A.rd1", busA.register1Data, 16'h0000);
      checkOutput("cleared B.rd2", busB.register2Data, 16'h0000);
      nextEdge();
    end

    applyStimulus(0, 1, 5, 16'hBEEF, 5, 5);
    #1;
    checkOutput("nobypass old r5", busB.register1Data, 16'h0000);
    checkOutput("bypass r5", busA.register1Data, 16'hBEEF);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 5, 5);
    #1;
    checkOutput("r5 port1", busB.register1Data, 16'hBEEF);
    checkOutput("r5 port2", busB.register2Data, 16'hBEEF);
    nextEdge();

    applyStimulus(0, 1, 7, 16'h1234, 0, 7);
    #1;
    checkOutput("bypass r7 port2", busA.register2Data, 16'h1234);
    checkOutput("nobypass r7 port2", busB.register2Data, 16'h0000);
    nextEdge();

    applyStimulus(0, 1, 0, 16'hFFFF, 0, 0);
    #1;
    checkOutput("zero reg bypass p1", busA.register1Data, 16'h0000);
    checkOutput("zero reg bypass p2", busA.register2Data, 16'h0000);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("zero reg p1", busA.register1Data, 16'h0000);
    checkOutput("plain r0 p2", busB.register2Data, 16'hFFFF);
    nextEdge();

    applyStimulus(0, 1, 3, 16'h00AA, 3, 4);
    nextEdge();
    applyStimulus(1, 1, 4, 16'h5555, 3, 4);
    #1;
    checkOutput("r3 before clear", busA.register1Data, 16'h00AA);
    nextEdge();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k == 5, k == 9, 2, 16'h7777, 3, 2);
      #1;
      checkOutput("busy during clear", {15'b0, busA.busy}, 16'd1);
      checkOutput("read during clear", busB.register1Data, 16'h0000);
      nextEdge();
    end
    checkOutput("busy after clear", {15'b0, busA.busy}, 16'd0);
    applyStimulus(0, 0, 0, 0, 3, 4);
    #1;
    checkOutput("r3 after clear", busB.register1Data, 16'h0000);
    checkOutput("r4 dropped", busB.register2Data, 16'h0000);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 2, 2);
    #1;
    checkOutput("mid-sweep write dropped", busB.register1Data, 16'h0000);
    nextEdge();

    applyStimulus(1, 0, 0, 0, 0, 0);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (9) nextEdge();
    reset = 1'b1;
    nextEdge();
    reset = 1'b0;
    #1;
    checkOutput("busy across reset", {15'b0, busA.busy}, 16'd1);
    countSweep("sweep length after mid reset");

    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) a1 = wa;
      if ($urandom_range(0, 3) == 0) a2 = wa;
      nextEdge();
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
